// File: rtl/rx_rst_ctrl.sv
// Receive-side reset sequencer: pulses the DCM reset, waits for a stable lock,
// then releases the rx engine; retries on lock timeout and recovers on lock loss.
module rx_rst_ctrl #(
  parameter int unsigned DCM_RST_CYCLES = 8,
  parameter int unsigned LOCK_TIMEOUT   = 4096,
  parameter int unsigned STABLE_CYCLES  = 256,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned RETRY_W        = 4
) (
  input  logic               rxclk,
  input  logic               reset,
  input  logic               locked,
  input  logic               lost_clr,
  output logic               dcm_rst,
  output logic               rx_reset,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_cnt
);

  typedef enum logic [1:0] {
    S_DCMRST,
    S_WAIT,
    S_STABLE,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] DCM_LAST    = CNT_W'(DCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic               sync1_q;
  logic               locked_s_q;
  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               dcm_rst_q;
  logic               rx_reset_q;
  logic               ready_q;
  logic               lock_lost_q;
  logic [RETRY_W-1:0] retry_q;

  // locked comes from the DCM and is not related to rxclk
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
    end else begin
      sync1_q    <= locked;
      locked_s_q <= sync1_q;
    end
  end

  // Outputs are updated together with the transition so the ports are pure flops
  always_ff @(posedge rxclk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_DCMRST;
      cnt_q       <= '0;
      dcm_rst_q   <= 1'b1;
      rx_reset_q  <= 1'b1;
      ready_q     <= 1'b0;
      lock_lost_q <= 1'b0;
      retry_q     <= '0;
    end else begin
      case (state_q)
        S_DCMRST: begin
          if (cnt_q == DCM_LAST) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            dcm_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (locked_s_q) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_q   <= S_DCMRST;
            cnt_q     <= '0;
            dcm_rst_q <= 1'b1;
            if (retry_q != '1) begin
              retry_q <= retry_q + RETRY_W'(1);
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STABLE: begin
          if (!locked_s_q) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q    <= S_RUN;
            cnt_q      <= '0;
            rx_reset_q <= 1'b0;
            ready_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_RUN: begin
          if (!locked_s_q) begin
            state_q    <= S_DCMRST;
            cnt_q      <= '0;
            dcm_rst_q  <= 1'b1;
            rx_reset_q <= 1'b1;
            ready_q    <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_DCMRST;
          cnt_q      <= '0;
          dcm_rst_q  <= 1'b1;
          rx_reset_q <= 1'b1;
          ready_q    <= 1'b0;
        end
      endcase

      // A loss detected on the same edge as a clear must not be dropped
      if (state_q == S_RUN && !locked_s_q) begin
        lock_lost_q <= 1'b1;
      end else if (lost_clr) begin
        lock_lost_q <= 1'b0;
      end
    end
  end

  assign dcm_rst   = dcm_rst_q;
  assign rx_reset  = rx_reset_q;
  assign ready     = ready_q;
  assign lock_lost = lock_lost_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_rx_rst_ctrl.sv
// Directed bench for rx_rst_ctrl with hand-computed edge-by-edge expectations.
module tb_rx_rst_ctrl;

  localparam int unsigned P_DCM    = 4;
  localparam int unsigned P_TO     = 32;
  localparam int unsigned P_STABLE = 16;

  logic       rxclk    = 1'b0;
  logic       reset    = 1'b1;
  logic       locked   = 1'b0;
  logic       lost_clr = 1'b0;
  logic       dcm_rst;
  logic       rx_reset;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_cnt;

  int n_chk = 0;
  int n_err = 0;
  int e     = 0;

  always #5 rxclk = ~rxclk;

  rx_rst_ctrl #(
    .DCM_RST_CYCLES(P_DCM),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STABLE),
    .CNT_W         (16),
    .RETRY_W       (4)
  ) dut (
    .rxclk    (rxclk),
    .reset    (reset),
    .locked   (locked),
    .lost_clr (lost_clr),
    .dcm_rst  (dcm_rst),
    .rx_reset (rx_reset),
    .ready    (ready),
    .lock_lost(lock_lost),
    .retry_cnt(retry_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  task automatic step();
    @(posedge rxclk);
    #1;
    e++;
  endtask

  task automatic go_to(input int t);
    while (e < t) step();
  endtask

  // Assert reset mid-cycle, check it acts immediately, release after the next edge
  task automatic apply_reset(input string tag);
    reset    = 1'b0;
    lost_clr = 1'b0;
    #1;
    chk({tag, ".dcm_rst"},   32'(dcm_rst),   32'd1);
    chk({tag, ".rx_reset"},  32'(rx_reset),  32'd1);
    chk({tag, ".ready"},     32'(ready),     32'd0);
    chk({tag, ".lock_lost"}, 32'(lock_lost), 32'd0);
    chk({tag, ".retry"},     32'(retry_cnt), 32'd0);
    @(posedge rxclk);
    #1;
    reset = 1'b1;
    e     = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    // 1: normal lock, locked first sampled at edge 10
    locked = 1'b0;
    apply_reset("t1.rst");
    chk("t1.dcm0", 32'(dcm_rst), 32'd1);
    go_to(3);  chk("t1.dcm3", 32'(dcm_rst), 32'd1);
    go_to(4);  chk("t1.dcm4", 32'(dcm_rst), 32'd0);
    go_to(9);  locked = 1'b1;
    go_to(27); chk("t1.rx27", 32'(rx_reset), 32'd1);
               chk("t1.rdy27", 32'(ready), 32'd0);
    go_to(28); chk("t1.rx28", 32'(rx_reset), 32'd0);
               chk("t1.rdy28", 32'(ready), 32'd1);
               chk("t1.retry", 32'(retry_cnt), 32'd0);
               chk("t1.dcm28", 32'(dcm_rst), 32'd0);

    // 2: no lock; 4-cycle pulse every 36 cycles, retry saturates at 15
    locked = 1'b0;
    #2;
    apply_reset("t2.rst");
    chk("t2.dcm", 32'(dcm_rst), 32'd1);
    for (int c = 1; c <= 36 * 17; c++) begin
      step();
      chk("t2.dcm", 32'(dcm_rst), ((e % 36) < 4) ? 32'd1 : 32'd0);
      chk("t2.retry", 32'(retry_cnt), ((e / 36) > 15) ? 32'd15 : 32'(e / 36));
      chk("t2.rx", 32'(rx_reset), 32'd1);
    end

    // 3: glitch in STABLE (entered after edge 12), low sampled at edges 20..22
    locked = 1'b0;
    #2;
    apply_reset("t3.rst");
    go_to(9);  locked = 1'b1;
    go_to(19); locked = 1'b0;
    go_to(22); locked = 1'b1;
    go_to(28); chk("t3.rx28", 32'(rx_reset), 32'd1);
    go_to(40); chk("t3.rx40", 32'(rx_reset), 32'd1);
               chk("t3.retry", 32'(retry_cnt), 32'd0);
               chk("t3.dcm40", 32'(dcm_rst), 32'd0);
    go_to(41); chk("t3.rx41", 32'(rx_reset), 32'd0);

    // 4: lock loss in RUN, low sampled at edge 45
    go_to(44); locked = 1'b0;
    go_to(46); chk("t4.rx46", 32'(rx_reset), 32'd0);
               chk("t4.lost46", 32'(lock_lost), 32'd0);
    go_to(47); chk("t4.rx47", 32'(rx_reset), 32'd1);
               chk("t4.dcm47", 32'(dcm_rst), 32'd1);
               chk("t4.lost47", 32'(lock_lost), 32'd1);
               chk("t4.rdy47", 32'(ready), 32'd0);
    go_to(49); locked = 1'b1;
    go_to(50); chk("t4.dcm50", 32'(dcm_rst), 32'd1);
    go_to(51); chk("t4.dcm51", 32'(dcm_rst), 32'd0);
    go_to(67); chk("t4.rx67", 32'(rx_reset), 32'd1);
    go_to(68); chk("t4.rx68", 32'(rx_reset), 32'd0);
               chk("t4.lost68", 32'(lock_lost), 32'd1);
               chk("t4.retry", 32'(retry_cnt), 32'd0);

    // 5: lone clear, then clear colliding with set at edge 77, then lone clear
    go_to(69); lost_clr = 1'b1;
    go_to(70); lost_clr = 1'b0;
               chk("t5.clr70", 32'(lock_lost), 32'd0);
    go_to(74); locked = 1'b0;
    go_to(76); lost_clr = 1'b1;
    go_to(77); lost_clr = 1'b0;
               chk("t5.coll77", 32'(lock_lost), 32'd1);
               chk("t5.rx77", 32'(rx_reset), 32'd1);
    go_to(79); lost_clr = 1'b1;
    go_to(80); lost_clr = 1'b0;
               chk("t5.clr80", 32'(lock_lost), 32'd0);

    // 6a: reset mid-STABLE, locked held high across reset
    locked = 1'b0;
    #2;
    apply_reset("t6a.rst0");
    go_to(9);  locked = 1'b1;
    go_to(20); #2;
    apply_reset("t6a.mid");
    chk("t6a.dcm0", 32'(dcm_rst), 32'd1);
    go_to(3);  chk("t6a.dcm3", 32'(dcm_rst), 32'd1);
    go_to(4);  chk("t6a.dcm4", 32'(dcm_rst), 32'd0);
    go_to(20); chk("t6a.rx20", 32'(rx_reset), 32'd1);
    go_to(21); chk("t6a.rx21", 32'(rx_reset), 32'd0);

    // 6b: reset in RUN with retry_cnt and lock_lost both set
    locked = 1'b0;
    #2;
    apply_reset("t6b.rst0");
    go_to(38); chk("t6b.retry38", 32'(retry_cnt), 32'd1);
    go_to(41); locked = 1'b1;
    go_to(60); chk("t6b.rx60", 32'(rx_reset), 32'd0);
    go_to(61); locked = 1'b0;
    go_to(64); chk("t6b.lost64", 32'(lock_lost), 32'd1);
    go_to(65); locked = 1'b1;
    go_to(84); chk("t6b.rx84", 32'(rx_reset), 32'd1);
    go_to(85); chk("t6b.rx85", 32'(rx_reset), 32'd0);
               chk("t6b.lost85", 32'(lock_lost), 32'd1);
               chk("t6b.retry85", 32'(retry_cnt), 32'd1);
    #2;
    apply_reset("t6b.run");
    chk("t6b.dcm0", 32'(dcm_rst), 32'd1);
    go_to(3);  chk("t6b.dcm3", 32'(dcm_rst), 32'd1);
    go_to(4);  chk("t6b.dcm4", 32'(dcm_rst), 32'd0);
    go_to(21); chk("t6b.rx21", 32'(rx_reset), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
